// File: rtl/n_bit_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_SPECIAL_EN to send divide-by-zero and signed overflow straight to DONE.
module n_bit_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         kill,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic signed [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] NEG_ONE_S = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    logic           div0_q, div0_d;
    logic           ovf_q, ovf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   result_q, result_d;

    logic           in_div, in_div_signed;
    logic           sign_a, sign_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [2*N-1:0] acc_step;
    logic signed [N-1:0] a_s, b_s;

    // Two's-complement sign correction of an N-bit magnitude.
    function automatic logic [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
        logic signed [N-1:0] m;
        m = mag;
        return neg ? -m : m;
    endfunction

    function automatic logic [2*N-1:0] apply_sign_wide(input logic [2*N-1:0] mag, input logic neg);
        logic signed [2*N-1:0] m;
        m = mag;
        return neg ? -m : m;
    endfunction

    // Fixed answers for divide-by-zero and most-negative / -1.
    function automatic logic [N-1:0] special_result(input logic [2:0] s_op,
                                                    input logic [N-1:0] s_a,
                                                    input logic s_div0);
        if (s_div0) begin
            return s_op[1] ? s_a : '1;
        end
        return s_op[1] ? '0 : s_a;
    endfunction

    // One shift-add step: acc = {partial high, remaining multiplier bits}.
    function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] m_acc,
                                                input logic [N-1:0] m_cand);
        logic [N:0] sum;
        sum = {1'b0, m_acc[2*N-1:N]} + (m_acc[0] ? {1'b0, m_cand} : {(N+1){1'b0}});
        return {sum, m_acc[N-1:1]};
    endfunction

    // One restoring-division step: acc = {partial remainder, dividend/quotient bits}.
    function automatic logic [2*N-1:0] div_step(input logic [2*N-1:0] d_acc,
                                                input logic [N-1:0] d_sor);
        logic [N:0] shifted;
        logic [N:0] diff;
        shifted = {d_acc[2*N-1:N], d_acc[N-1]};
        diff    = shifted - {1'b0, d_sor};
        if (!diff[N]) begin
            return {diff[N-1:0], d_acc[N-2:0], 1'b1};
        end
        return {shifted[N-1:0], d_acc[N-2:0], 1'b0};
    endfunction

    function automatic logic [N-1:0] finalize(input logic [2:0] f_op,
                                              input logic [2*N-1:0] f_acc,
                                              input logic f_neg,
                                              input logic f_div0,
                                              input logic f_ovf,
                                              input logic [N-1:0] f_a);
        logic [2*N-1:0] prod;
        if (f_op[2]) begin
            if (f_div0 || f_ovf) begin
                return special_result(f_op, f_a, f_div0);
            end
            return apply_sign(f_op[1] ? f_acc[2*N-1:N] : f_acc[N-1:0], f_neg);
        end
        prod = apply_sign_wide(f_acc, f_neg);
        return (f_op == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
    endfunction

    // Operand signedness and magnitudes, taken straight from the request inputs.
    always_comb begin
        a_s           = a;
        b_s           = b;
        in_div        = op[2];
        in_div_signed = (op == OP_DIV) || (op == OP_REM);
        if (in_div) begin
            sign_a = in_div_signed && a[N-1];
            sign_b = in_div_signed && b[N-1];
        end else begin
            sign_a = ((op == OP_MULH) || (op == OP_MULHSU)) && a[N-1];
            sign_b = (op == OP_MULH) && b[N-1];
        end
        mag_a = apply_sign(a, sign_a);
        mag_b = apply_sign(b, sign_b);
    end

    assign acc_step = op_q[2] ? div_step(acc_q, mcand_q) : mul_step(acc_q, mcand_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d    = op;
                    a_d     = a;
                    mcand_d = in_div ? mag_b : mag_a;
                    acc_d   = {{N{1'b0}}, (in_div ? mag_a : mag_b)};
                    // REM follows the dividend sign; every other op uses the xor.
                    neg_d   = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
                    div0_d  = in_div && (b == '0);
                    ovf_d   = in_div_signed && (a_s == MIN_S) && (b_s == NEG_ONE_S);
                    cnt_d   = '0;
`ifdef MULDIV_FAST_SPECIAL_EN
                    if (div0_d || ovf_d) begin
                        state_d  = DONE;
                        result_d = special_result(op, a, div0_d);
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d  = DONE;
                        result_d = finalize(op_q, acc_step, neg_q, div0_q, ovf_q, a_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_n_bit_muldiv.sv
// Self-checking bench for n_bit_muldiv (N=32): directed cases, kill/reset/start-in-DONE, random ops vs. arithmetic model.
module tb_n_bit_muldiv;

    localparam int N = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          kill = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          ready;
    logic          done;
    logic [N-1:0]  result;

    int checks = 0;
    int passes = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    n_bit_muldiv #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference arithmetic with 64-bit integers.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sp;
        longint unsigned ux, uy, up;
        logic ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = 64'(x);
        uy  = 64'(y);
        ovf = (x == MIN32) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin up = ux * uy; return up[31:0]; end
            3'd1: begin sp = sx * sy; return sp[63:32]; end
            3'd2: begin sp = sx * longint'(uy); return sp[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                sp = sx / sy; return sp[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                up = ux / uy; return up[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                sp = sx % sy; return sp[31:0];
            end
            default: begin
                if (y == 0) return x;
                up = ux % uy; return up[31:0];
            end
        endcase
    endfunction

    function automatic int expected_edge(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic special;
        special = o[2] && ((y == 0) || (!o[0] && x == MIN32 && y == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_SPECIAL_EN
        if (special) return 1;
`else
        if (special) return N + 1;
`endif
        return N + 1;
    endfunction

    // Returns the number of edges after the accepting edge until done is visible.
    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        int c;
        logic [31:0] exp;
        exp = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        check({tag, " busy"}, 64'(ready), 64'(0));
        wait_done(c);
        check({tag, " done edge"}, 64'(c + 1), 64'(expected_edge(o, x, y)));
        check({tag, " result"}, 64'(result), 64'(exp));
        last_exp = exp;
        @(posedge clk);
        #1;
        check({tag, " done width"}, 64'(done), 64'(0));
    endtask

    initial begin
        int c;
        int seen;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 64'(ready), 64'(1));
        check("rst done", 64'(done), 64'(0));
        check("rst result", 64'(result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, "mul");
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, "mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
        run_op(3'd5, 32'd7, 32'd2, "divu");
        run_op(3'd5, 32'd5, 32'd0, "divu by zero");
        run_op(3'd7, 32'd5, 32'd0, "remu by zero");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, "div by zero");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, "rem by zero");
        run_op(3'd4, MIN32, 32'hFFFF_FFFF, "div overflow");
        run_op(3'd6, MIN32, 32'hFFFF_FFFF, "rem overflow");
        run_op(3'd1, MIN32, MIN32, "mulh min");

        // kill 10 cycles into CALC
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = $urandom; b = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill ready", 64'(ready), 64'(1));
        check("kill done", 64'(done), 64'(0));
        check("kill result", 64'(result), 64'(last_exp));
        seen = 0;
        repeat (N + 4) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("kill no done", 64'(seen), 64'(0));

        // start together with kill in IDLE is not an accept
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("start+kill idle", 64'(ready), 64'(1));

        // start during DONE is ignored; accepted on the following edge
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c);
        check("first op result", 64'(result), 64'(14));
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(posedge clk);
        #1;
        check("start in done ignored", 64'(ready), 64'(1));
        check("result held after done", 64'(result), 64'(14));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept after done", 64'(ready), 64'(0));
        wait_done(c);
        check("second op edge", 64'(c + 1), 64'(N + 1));
        check("second op result", 64'(result), 64'(42));
        last_exp = 32'd42;
        @(posedge clk);
        #1;

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = MIN32; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, "random");
        end

        // reset mid-CALC
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst done", 64'(done), 64'(0));
        check("mid rst result", 64'(result), 64'(0));
        check("mid rst ready", 64'(ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 4) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("mid rst no done", 64'(seen), 64'(0));

        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, "remu after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
